pixel_event_requester: RTL and testbench
========================================

// Module: pixel_event_requester
// PURPOSE
//  Requester side of the row/column AER handshake: sits between a group of WIDTH pixel comparators and y_roundrobin.
//  Latches single-cycle pixel events and raises req_o for each pending pixel. Drops a request on grant, then holds
//  the pixel in a refractory period. Events arriving mid-round are deferred until the arbiter releases the group.
// PARAMETERS
//  WIDTH          8   pixels per group; must match arbiter WIDTH
//  REFRACT_CYCLES 4   cycles a pixel stays dead after grant (>=1)
//  DROP_W         8   width of saturating dropped-event counter
// PORTS
//  clk_i          in   1            clock
//  reset_i        in   1            asynchronous, active-high reset
//  enable_i       in   1            group enable; same signal that drives the arbiter enable_i
//  event_i        in   WIDTH        per-pixel event pulse (1 cycle)
//  pol_i          in   WIDTH        per-pixel polarity, sampled with event_i
//  gnt_i          in   WIDTH        registered one-hot grant from arbiter
//  grp_release_i  in   1            arbiter group-release pulse
//  req_o          out  WIDTH        request lines to arbiter
//  ev_valid_o     out  1            1-cycle pulse, accepted grant
//  ev_addr_o      out  $clog2(WIDTH) index of granted pixel
//  ev_pol_o       out  1            stored polarity of granted pixel
//  drop_cnt_o     out  DROP_W       saturating count of lost events
//  err_o          out  1            sticky protocol error
// BEHAVIOUR
//  Reset (async): all cells IDLE; req_o=0, ev_valid_o=0, ev_addr_o=0, ev_pol_o=0, drop_cnt_o=0, err_o=0, round_active=0.
//  Per-pixel FSM, states IDLE / PENDING / REFRACT:
//   IDLE: event_i[i] -> PENDING next cycle; latch pol_i[i]. Set deferred[i]=round_active.
//   PENDING: req_o[i] = ~deferred[i] (registered, no combinational path from inputs).
//    gnt_i[i] -> REFRACT, counter=REFRACT_CYCLES-1. req_o[i]=0 from the next cycle.
//    event_i[i] without grant: merged and dropped, drop_cnt_o+1.
//   REFRACT: counter decrements each cycle; at 0 -> IDLE. Any event_i[i] is dropped, drop_cnt_o+1.
//    With REFRACT_CYCLES=1, the cell re-arms one cycle after the grant cycle.
//  Round tracking:
//   - round_active sets on the first accepted grant and clears on grp_release_i.
//   - grp_release_i clears all deferred bits; those pixels assert req_o the following cycle.
//   - grp_release_i and an accepted grant in the same cycle: the release is applied after the grant, leaving
//     round_active=0. A new event that cycle is not deferred.
//  Grant acceptance:
//   - gnt_i one-hot on a PENDING, non-deferred pixel -> next cycle ev_valid_o=1, ev_addr_o=index, ev_pol_o=latched pol.
//   - gnt_i on a non-requesting pixel, or gnt_i not one-hot/zero -> err_o=1 (sticky until reset); cells unchanged,
//     no ev_valid_o.
//   - Grant and event on the same PENDING pixel in one cycle: grant wins, event dropped and counted.
//  drop_cnt_o adds the number of pixels dropping an event in that cycle (popcount), saturating at 2**DROP_W-1.
//  enable_i=0: synchronous clear of all cells to IDLE, deferred=0, round_active=0, req_o=0, ev_valid_o=0.
//   Events while disabled are ignored and not counted. drop_cnt_o and err_o hold.
//  Reset mid-round: all state cleared immediately; no ev_valid_o is produced for in-flight grants.
// STRUCTURE
//  ebc_pkg:
//   - pix_state_t enum {PIX_IDLE, PIX_PENDING, PIX_REFRACT}
//   - ADDR_W function/constant
//   - DROP_SAT constant shared with the column receiver
//  Sub-module pixel_req_cell: one instance per pixel via generate.
//   - Contains the per-pixel FSM, refractory counter, polarity latch and deferred bit.
//   - Outputs req, drop, pending.
//  Top level holds round_active, grant check/one-hot encoder, event output register, drop counter and err flag.
// TESTING
//  1. event_i=8'h05 at t0, no grants -> req_o=8'h05 at t0+1, held steady.
//  2. From (1), gnt_i=8'h01 -> next cycle req_o=8'h04, ev_valid_o=1, ev_addr_o=0. Pixel 0 re-arms exactly 4 cycles
//     after the grant cycle. An event on pixel 0 at grant+2 -> drop_cnt_o=1.
//  3. round_active=1, event on pixel 6 -> req_o[6]=0. grp_release_i pulse -> req_o[6]=1 the next cycle.
//  4. gnt_i=8'h10 with req_o[4]=0 -> err_o=1 sticky, ev_valid_o=0. Also gnt_i=8'h03 -> err_o=1.
//  5. Pixel 3 PENDING, event_i[3] and gnt_i[3] same cycle -> grant accepted, drop_cnt_o+1. Saturation: 300 drops
//     -> drop_cnt_o=255.
//  6. enable_i=0 with 3 pending and 1 refractory -> req_o=0 the next cycle, all cells IDLE. Async reset mid-grant
//     -> every output at its reset value.

Source files
------------

// File: rtl/ebc_pkg.sv
// rtl/ebc_pkg.sv - shared types and constants for the event-based pixel requester and column receiver
package ebc_pkg;

  typedef enum logic [1:0] {
    PIX_IDLE,
    PIX_PENDING,
    PIX_REFRACT
  } pix_state_t;

  localparam int DROP_W_DEF = 8;
  localparam logic [DROP_W_DEF-1:0] DROP_SAT = '1;

  function automatic int addr_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/pixel_req_cell.sv
// rtl/pixel_req_cell.sv - per-pixel request FSM with polarity latch, deferred bit and refractory counter
module pixel_req_cell
  import ebc_pkg::*;
#(
  parameter int REFRACT_CYCLES = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic i_enable,
  input  logic i_event,
  input  logic i_pol,
  input  logic i_grant,
  input  logic i_release,
  input  logic i_defer,
  output logic o_req,
  output logic o_drop,
  output logic o_pending,
  output logic o_pol
);

  localparam int CNT_W = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;

  pix_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_deferred;
  logic             r_pol;
  logic             w_dead;

  // A refractory cell whose counter has reached zero is already re-armed.
  assign w_dead    = (r_state == PIX_PENDING) || ((r_state == PIX_REFRACT) && (r_cnt != '0));
  assign o_drop    = i_enable & i_event & w_dead;
  assign o_req     = (r_state == PIX_PENDING) & ~r_deferred;
  assign o_pending = (r_state == PIX_PENDING);
  assign o_pol     = r_pol;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= PIX_IDLE;
      r_cnt      <= '0;
      r_deferred <= 1'b0;
      r_pol      <= 1'b0;
    end else if (!i_enable) begin
      r_state    <= PIX_IDLE;
      r_cnt      <= '0;
      r_deferred <= 1'b0;
    end else begin
      case (r_state)
        PIX_PENDING: begin
          if (i_grant) begin
            r_state    <= PIX_REFRACT;
            r_cnt      <= CNT_W'(REFRACT_CYCLES - 1);
            r_deferred <= 1'b0;
          end else if (i_release) begin
            r_deferred <= 1'b0;
          end
        end
        default: begin
          if ((r_state == PIX_REFRACT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (i_event) begin
            r_state    <= PIX_PENDING;
            r_pol      <= i_pol;
            r_deferred <= i_defer;
          end else begin
            r_state <= PIX_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/pixel_event_requester.sv
// rtl/pixel_event_requester.sv - AER requester: pixel cells, round tracking, grant check, event output and drop counter
module pixel_event_requester
  import ebc_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int REFRACT_CYCLES = 4,
  parameter int DROP_W         = DROP_W_DEF
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       enable_i,
  input  logic [WIDTH-1:0]           event_i,
  input  logic [WIDTH-1:0]           pol_i,
  input  logic [WIDTH-1:0]           gnt_i,
  input  logic                       grp_release_i,
  output logic [WIDTH-1:0]           req_o,
  output logic                       ev_valid_o,
  output logic [addr_w(WIDTH)-1:0]   ev_addr_o,
  output logic                       ev_pol_o,
  output logic [DROP_W-1:0]          drop_cnt_o,
  output logic                       err_o
);

  localparam int ADDR_W = addr_w(WIDTH);
  localparam logic [DROP_W-1:0] SAT = '1;

  logic [WIDTH-1:0]  w_req, w_drop, w_pending, w_pol, w_cell_gnt;
  logic              w_onehot, w_hit, w_accept, w_bad, w_round_next, w_pol_sel, w_ovf;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_pop, w_sum;

  logic              r_round;
  logic              r_ev_valid;
  logic [ADDR_W-1:0] r_ev_addr;
  logic              r_ev_pol;
  logic [DROP_W-1:0] r_drop_cnt;
  logic              r_err;

  assign w_onehot     = (gnt_i != '0) && ((gnt_i & (gnt_i - WIDTH'(1))) == '0);
  assign w_hit        = |(gnt_i & w_req & w_pending);
  assign w_accept     = enable_i & w_onehot & w_hit;
  assign w_bad        = enable_i & (gnt_i != '0) & ~(w_onehot & w_hit);
  // Release is applied after the grant, so a simultaneous release ends the round.
  assign w_round_next = grp_release_i ? 1'b0 : (w_accept | r_round);
  assign w_cell_gnt   = w_accept ? gnt_i : '0;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    pixel_req_cell #(.REFRACT_CYCLES(REFRACT_CYCLES)) u_cell (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .i_enable  (enable_i),
      .i_event   (event_i[g]),
      .i_pol     (pol_i[g]),
      .i_grant   (w_cell_gnt[g]),
      .i_release (grp_release_i),
      .i_defer   (w_round_next),
      .o_req     (w_req[g]),
      .o_drop    (w_drop[g]),
      .o_pending (w_pending[g]),
      .o_pol     (w_pol[g])
    );
  end

  always_comb begin
    w_addr = '0;
    w_pop  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (gnt_i[i]) w_addr = ADDR_W'(i);
      w_pop = w_pop + 32'(w_drop[i]);
    end
    w_pol_sel = |(gnt_i & w_pol);
  end

  assign w_sum = 32'(r_drop_cnt) + w_pop;
  assign w_ovf = |(w_sum >> DROP_W);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_round    <= 1'b0;
      r_ev_valid <= 1'b0;
      r_ev_addr  <= '0;
      r_ev_pol   <= 1'b0;
      r_drop_cnt <= '0;
      r_err      <= 1'b0;
    end else if (!enable_i) begin
      r_round    <= 1'b0;
      r_ev_valid <= 1'b0;
    end else begin
      r_round    <= w_round_next;
      r_ev_valid <= w_accept;
      if (w_accept) begin
        r_ev_addr <= w_addr;
        r_ev_pol  <= w_pol_sel;
      end
      if (w_bad) r_err <= 1'b1;
      r_drop_cnt <= w_ovf ? SAT : w_sum[DROP_W-1:0];
    end
  end

  assign req_o      = w_req;
  assign ev_valid_o = r_ev_valid;
  assign ev_addr_o  = r_ev_addr;
  assign ev_pol_o   = r_ev_pol;
  assign drop_cnt_o = r_drop_cnt;
  assign err_o      = r_err;

endmodule

// File: tb/tb_pixel_event_requester.sv
// tb/tb_pixel_event_requester.sv - scoreboard bench with a cycle-level reference model of the requester
module tb_pixel_event_requester;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int DW = 8;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          enable_i;
  logic [W-1:0]  event_i, pol_i, gnt_i;
  logic          grp_release_i;
  logic [W-1:0]  req_o;
  logic          ev_valid_o;
  logic [2:0]    ev_addr_o;
  logic          ev_pol_o;
  logic [DW-1:0] drop_cnt_o;
  logic          err_o;

  always #5 clk_i = ~clk_i;

  pixel_event_requester #(.WIDTH(W), .REFRACT_CYCLES(R), .DROP_W(DW)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .enable_i      (enable_i),
    .event_i       (event_i),
    .pol_i         (pol_i),
    .gnt_i         (gnt_i),
    .grp_release_i (grp_release_i),
    .req_o         (req_o),
    .ev_valid_o    (ev_valid_o),
    .ev_addr_o     (ev_addr_o),
    .ev_pol_o      (ev_pol_o),
    .drop_cnt_o    (drop_cnt_o),
    .err_o         (err_o)
  );

  typedef struct packed {
    logic [2:0] addr;
    logic       pol;
  } ev_t;

  int     n_checks = 0;
  int     n_err    = 0;
  int     cyc      = 0;
  ev_t    exp_q[$];
  ev_t    mon_e;

  logic [W-1:0] m_pend, m_def, m_pol;
  int           m_dead_until[W];
  logic         m_round, m_err;
  int           m_drop;

  function automatic logic [W-1:0] m_req();
    return m_pend & ~m_def;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_def = '0; m_pol = '0;
    m_round = 1'b0; m_err = 1'b0; m_drop = 0;
    for (int i = 0; i < W; i++) m_dead_until[i] = 0;
    exp_q.delete();
  endtask

  // One clock of the reference behaviour; a pixel is dead from the cycle after its grant
  // until R cycles after the grant cycle.
  task automatic model_step(input logic en, input logic [W-1:0] ev, input logic [W-1:0] pl,
                            input logic [W-1:0] gnt, input logic rel);
    logic [W-1:0] req;
    logic         accept, rnext;
    int           drops;
    if (!en) begin
      m_pend = '0; m_def = '0; m_round = 1'b0;
      for (int i = 0; i < W; i++) m_dead_until[i] = 0;
      return;
    end
    req    = m_req();
    accept = ($countones(gnt) == 1) && ((gnt & req) != '0);
    if (gnt != '0 && !accept) m_err = 1'b1;
    rnext  = rel ? 1'b0 : (accept ? 1'b1 : m_round);
    drops  = 0;
    for (int i = 0; i < W; i++) begin
      if (m_pend[i]) begin
        if (ev[i]) drops++;
        if (accept && gnt[i]) begin
          exp_q.push_back('{addr: 3'(i), pol: m_pol[i]});
          m_pend[i] = 1'b0;
          m_def[i]  = 1'b0;
          m_dead_until[i] = cyc + R;
        end else if (rel) begin
          m_def[i] = 1'b0;
        end
      end else if (cyc < m_dead_until[i]) begin
        if (ev[i]) drops++;
      end else if (ev[i]) begin
        m_pend[i] = 1'b1;
        m_pol[i]  = pl[i];
        m_def[i]  = rnext;
      end
    end
    m_drop  = (m_drop + drops > 255) ? 255 : m_drop + drops;
    m_round = rnext;
  endtask

  task automatic tick(input logic en, input logic [W-1:0] ev, input logic [W-1:0] pl,
                      input logic [W-1:0] gnt, input logic rel);
    enable_i = en; event_i = ev; pol_i = pl; gnt_i = gnt; grp_release_i = rel;
    @(posedge clk_i);
    model_step(en, ev, pl, gnt, rel);
    cyc++;
    @(negedge clk_i);
    chk("req_o", 32'(req_o), 32'(m_req()));
    chk("drop_cnt_o", 32'(drop_cnt_o), 32'(m_drop));
    chk("err_o", 32'(err_o), 32'(m_err));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b1, '0, '0, '0, 1'b0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"}, 32'(req_o), 0);
    chk({tag, "_ev_valid"}, 32'(ev_valid_o), 0);
    chk({tag, "_ev_addr"}, 32'(ev_addr_o), 0);
    chk({tag, "_ev_pol"}, 32'(ev_pol_o), 0);
    chk({tag, "_drop"}, 32'(drop_cnt_o), 0);
    chk({tag, "_err"}, 32'(err_o), 0);
  endtask

  task automatic do_reset();
    #1;
    reset_i = 1'b1;
    enable_i = 1'b1; event_i = '0; pol_i = '0; gnt_i = '0; grp_release_i = 1'b0;
    model_reset();
    #1;
    chk_reset_outs("rst");
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  // Every accepted grant must appear exactly one cycle later, in order.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (ev_valid_o) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL ev_unexpected: got addr=%0d pol=%0d expected no event", ev_addr_o, ev_pol_o);
        end else begin
          mon_e = exp_q.pop_front();
          if ({ev_addr_o, ev_pol_o} !== mon_e) begin
            n_err++;
            $display("FAIL ev_data: got addr=%0d pol=%0d expected addr=%0d pol=%0d",
                     ev_addr_o, ev_pol_o, mon_e.addr, mon_e.pol);
          end
        end
      end else if (exp_q.size() != 0) begin
        n_checks++;
        n_err++;
        $display("FAIL ev_missing: got ev_valid_o=0 expected addr=%0d", exp_q[0].addr);
        exp_q.delete();
      end
    end
  end

  initial begin
    logic [W-1:0] ev, pl, gnt, rq;
    int           idx;

    reset_i = 1'b1;
    enable_i = 1'b0; event_i = '0; pol_i = '0; gnt_i = '0; grp_release_i = 1'b0;
    model_reset();
    #12;
    chk_reset_outs("init");
    @(negedge clk_i);
    reset_i = 1'b0;

    tick(1'b1, 8'h05, 8'h04, '0, 1'b0);
    chk("t1_req", 32'(req_o), 32'h05);
    idle(2);
    chk("t1_req_held", 32'(req_o), 32'h05);

    tick(1'b1, '0, '0, 8'h01, 1'b0);
    chk("t2_req_after_gnt", 32'(req_o), 32'h04);
    idle(1);
    tick(1'b1, 8'h01, 8'h01, '0, 1'b0);
    chk("t2_refract_drop", 32'(drop_cnt_o), 1);
    idle(1);
    tick(1'b1, 8'h01, 8'h01, '0, 1'b0);
    chk("t2_rearm_deferred", 32'(req_o), 32'h04);

    tick(1'b1, 8'h40, 8'h40, '0, 1'b0);
    chk("t3_deferred_req", 32'(req_o), 32'h04);
    tick(1'b1, '0, '0, '0, 1'b1);
    chk("t3_release_req", 32'(req_o), 32'h45);

    tick(1'b1, 8'h08, 8'h08, '0, 1'b0);
    tick(1'b1, 8'h08, 8'h00, 8'h08, 1'b0);
    chk("t5_same_cycle_drop", 32'(drop_cnt_o), 2);

    tick(1'b1, '0, '0, 8'h10, 1'b0);
    chk("t4_err_idle_pixel", 32'(err_o), 1);
    idle(2);
    chk("t4_err_sticky", 32'(err_o), 1);
    do_reset();
    tick(1'b1, '0, '0, 8'h03, 1'b0);
    chk("t4_err_multihot", 32'(err_o), 1);

    do_reset();
    for (int k = 0; k < 40; k++) tick(1'b1, 8'hFF, 8'hAA, '0, 1'b0);
    chk("t5_saturation", 32'(drop_cnt_o), 255);

    do_reset();
    tick(1'b1, 8'h0F, 8'h0A, '0, 1'b0);
    tick(1'b1, '0, '0, 8'h01, 1'b0);
    tick(1'b0, 8'hF0, 8'hF0, '0, 1'b0);
    chk("t6_disable_req", 32'(req_o), 0);
    tick(1'b1, 8'h01, 8'h01, '0, 1'b0);
    chk("t6_reenable_req", 32'(req_o), 32'h01);

    do_reset();
    tick(1'b1, 8'h20, 8'h20, '0, 1'b0);
    gnt_i = 8'h20;
    #2;
    reset_i = 1'b1;
    model_reset();
    #1;
    chk_reset_outs("async");
    @(negedge clk_i);
    reset_i = 1'b0;
    idle(2);
    chk("async_no_req", 32'(req_o), 0);

    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      ev  = W'($urandom & $urandom & $urandom);
      pl  = W'($urandom);
      gnt = '0;
      rq  = m_req();
      if (rq != '0 && $urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, W - 1);
        while (!rq[idx]) idx = (idx + 1) % W;
        gnt[idx] = 1'b1;
      end else if ($urandom_range(0, 59) == 0) begin
        gnt = W'($urandom);
      end
      tick($urandom_range(0, 49) != 0, ev, pl, gnt, $urandom_range(0, 7) == 0);
    end

    idle(2);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
